// File: rtl/debounce_pkg.sv
// Shared constants, repeat-engine state type and sizing helper for the
// multi-channel push-button conditioner.
package debounce_pkg;

    localparam int DEF_STABLE_CYCLES = 1000;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_RPT_DELAY     = 50_000_000;
    localparam int DEF_RPT_PERIOD    = 10_000_000;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One button channel: input synchroniser, consecutive-stable filter with
// edge pulses, and a hold-to-repeat engine.
module debounce_ch
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int RPT_DELAY     = DEF_RPT_DELAY,
    parameter int RPT_PERIOD    = DEF_RPT_PERIOD,
    localparam int CNT_W        = $clog2(STABLE_CYCLES + 1),
    localparam int RPT_W        = $clog2(max_int(RPT_DELAY, RPT_PERIOD) + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    input  logic rpt_en,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic btn_rpt
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   level_r;
    logic                   level_nxt_s;
    logic                   flip_s;
    logic                   rise_evt_s;
    logic                   fall_evt_s;
    logic                   rise_r;
    logic                   fall_r;

    rpt_state_t             state_r;
    rpt_state_t             state_nxt_s;
    logic [RPT_W-1:0]       rcnt_r;
    logic [RPT_W-1:0]       rcnt_nxt_s;
    logic                   rpt_r;
    logic                   rpt_nxt_s;

    assign sync_s     = sync_r[SYNC_STAGES-1];
    assign rise_evt_s = flip_s & ~level_r;
    assign fall_evt_s = flip_s &  level_r;

    assign btn_level  = level_r;
    assign btn_rise   = rise_r;
    assign btn_fall   = fall_r;
    assign btn_rpt    = rpt_r;

    // Stability filter: count consecutive disagreements, flip on the last one.
    always_comb begin
        cnt_nxt_s   = cnt_r;
        level_nxt_s = level_r;
        flip_s      = 1'b0;
        if (sync_s == level_r) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_W'(STABLE_CYCLES - 1)) begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            level_nxt_s = ~level_r;
            flip_s      = 1'b1;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Synchroniser chain, filter state and registered edge pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r  <= {SYNC_STAGES{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync_r  <= {sync_r[SYNC_STAGES-2:0], btn_in};
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            rise_r  <= rise_evt_s;
            fall_r  <= fall_evt_s;
        end
    end

    // Repeat engine next state. Entering DELAY on the flip edge itself puts
    // the first pulse exactly RPT_DELAY cycles after the rise pulse; an
    // IDLE channel that is already held re-arms when rpt_en returns.
    always_comb begin
        state_nxt_s = state_r;
        rcnt_nxt_s  = rcnt_r;
        rpt_nxt_s   = 1'b0;
        case (state_r)
            debounce_pkg::RPT_IDLE: begin
                rcnt_nxt_s = {RPT_W{1'b0}};
                if (rpt_en && !fall_evt_s && (rise_evt_s || level_r)) begin
                    state_nxt_s = debounce_pkg::RPT_DELAY;
                end else begin
                    state_nxt_s = debounce_pkg::RPT_IDLE;
                end
            end
            debounce_pkg::RPT_DELAY: begin
                if (fall_evt_s || !rpt_en) begin
                    state_nxt_s = debounce_pkg::RPT_IDLE;
                    rcnt_nxt_s  = {RPT_W{1'b0}};
                end else if (rcnt_r == RPT_W'(RPT_DELAY - 1)) begin
                    state_nxt_s = debounce_pkg::RPT_REPEAT;
                    rcnt_nxt_s  = {RPT_W{1'b0}};
                    rpt_nxt_s   = 1'b1;
                end else begin
                    rcnt_nxt_s = rcnt_r + RPT_W'(1);
                end
            end
            debounce_pkg::RPT_REPEAT: begin
                if (fall_evt_s || !rpt_en) begin
                    state_nxt_s = debounce_pkg::RPT_IDLE;
                    rcnt_nxt_s  = {RPT_W{1'b0}};
                end else if (rcnt_r == RPT_W'(RPT_PERIOD - 1)) begin
                    rcnt_nxt_s = {RPT_W{1'b0}};
                    rpt_nxt_s  = 1'b1;
                end else begin
                    rcnt_nxt_s = rcnt_r + RPT_W'(1);
                end
            end
            default: begin
                state_nxt_s = debounce_pkg::RPT_IDLE;
                rcnt_nxt_s  = {RPT_W{1'b0}};
            end
        endcase
    end

    // Repeat engine state register and registered repeat pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= debounce_pkg::RPT_IDLE;
            rcnt_r  <= {RPT_W{1'b0}};
            rpt_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            rcnt_r  <= rcnt_nxt_s;
            rpt_r   <= rpt_nxt_s;
        end
    end

endmodule

// File: rtl/multi_debounce.sv
// N-channel push-button conditioner: independent debounce_ch instances
// sharing clock, reset and the global repeat enable.
module multi_debounce
    import debounce_pkg::*;
#(
    parameter int N_CH          = 5,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int RPT_DELAY     = DEF_RPT_DELAY,
    parameter int RPT_PERIOD    = DEF_RPT_PERIOD
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    input  logic            rpt_en,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_rise,
    output logic [N_CH-1:0] btn_fall,
    output logic [N_CH-1:0] btn_rpt
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES),
            .RPT_DELAY     (RPT_DELAY),
            .RPT_PERIOD    (RPT_PERIOD)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .btn_in    (btn_in[i]),
            .rpt_en    (rpt_en),
            .btn_level (btn_level[i]),
            .btn_rise  (btn_rise[i]),
            .btn_fall  (btn_fall[i]),
            .btn_rpt   (btn_rpt[i])
        );
    end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce with short filter and repeat timings.
module tb_multi_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn_in;
    logic       rpt_en;
    logic [1:0] btn_level;
    logic [1:0] btn_rise;
    logic [1:0] btn_fall;
    logic [1:0] btn_rpt;

    int n_checks = 0;
    int n_fail   = 0;

    multi_debounce #(
        .N_CH          (2),
        .STABLE_CYCLES (4),
        .SYNC_STAGES   (2),
        .RPT_DELAY     (10),
        .RPT_PERIOD    (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .rpt_en    (rpt_en),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .btn_rpt   (btn_rpt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // Advance one clock edge and compare every output 1 ns after it.
    task automatic tick_chk(input string tag, input logic [1:0] e_lvl, input logic [1:0] e_rise,
                            input logic [1:0] e_fall, input logic [1:0] e_rpt);
        @(posedge clk);
        #1;
        check_eq({tag, "_lvl"},  btn_level, e_lvl);
        check_eq({tag, "_rise"}, btn_rise,  e_rise);
        check_eq({tag, "_fall"}, btn_fall,  e_fall);
        check_eq({tag, "_rpt"},  btn_rpt,   e_rpt);
    endtask

    initial begin
        rst_n  = 1'b0;
        btn_in = 2'b00;
        rpt_en = 1'b0;
        tick_chk("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        tick_chk("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
        tick_chk("idle", 2'b00, 2'b00, 2'b00, 2'b00);

        // Clean press, repeat disabled: no repeat pulses during a long hold.
        btn_in = 2'b01;
        for (int k = 0; k < 26; k++)
            tick_chk("press", (k >= 5) ? 2'b01 : 2'b00, (k == 5) ? 2'b01 : 2'b00, 2'b00, 2'b00);

        // Dropouts inside the held press: 3-low, 1-high, 3-low, then 1-cycle lows.
        for (int k = 0; k < 18; k++) begin
            btn_in[0] = !((k <= 2) || (k >= 4 && k <= 6) || (k == 9) || (k == 11));
            tick_chk("dropout", 2'b01, 2'b00, 2'b00, 2'b00);
        end

        // Release.
        btn_in = 2'b00;
        for (int k = 0; k < 10; k++)
            tick_chk("release", (k < 5) ? 2'b01 : 2'b00, 2'b00, (k == 5) ? 2'b01 : 2'b00, 2'b00);

        // Short high glitch from the released state.
        for (int k = 0; k < 12; k++) begin
            btn_in[0] = (k < 3);
            tick_chk("glitch", 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // Auto-repeat: pulses at rise+10, +13, +16.
        rpt_en = 1'b1;
        btn_in = 2'b01;
        for (int k = 0; k < 23; k++)
            tick_chk("rpt", (k >= 5) ? 2'b01 : 2'b00, (k == 5) ? 2'b01 : 2'b00, 2'b00,
                     (k == 15 || k == 18 || k == 21) ? 2'b01 : 2'b00);

        // Drop rpt_en between pulses: the pulse due two edges later is suppressed.
        rpt_en = 1'b0;
        for (int k = 0; k < 6; k++)
            tick_chk("rpt_off", 2'b01, 2'b00, 2'b00, 2'b00);

        // Re-assert: next pulse 10 cycles later, then every 3.
        rpt_en = 1'b1;
        for (int k = 0; k < 14; k++)
            tick_chk("rpt_re", 2'b01, 2'b00, 2'b00, (k == 10 || k == 13) ? 2'b01 : 2'b00);

        // Release while repeating: pulse at +2 still due, none at or after the fall.
        btn_in = 2'b00;
        for (int k = 0; k < 11; k++)
            tick_chk("rpt_rel", (k < 5) ? 2'b01 : 2'b00, 2'b00, (k == 5) ? 2'b01 : 2'b00,
                     (k == 2) ? 2'b01 : 2'b00);

        // Simultaneous channels.
        rpt_en = 1'b0;
        btn_in = 2'b11;
        for (int k = 0; k < 7; k++)
            tick_chk("sim", (k >= 5) ? 2'b11 : 2'b00, (k == 5) ? 2'b11 : 2'b00, 2'b00, 2'b00);
        btn_in = 2'b00;
        for (int k = 0; k < 7; k++)
            tick_chk("sim_rel", (k < 5) ? 2'b11 : 2'b00, 2'b00, (k == 5) ? 2'b11 : 2'b00, 2'b00);

        // Staggered by one cycle.
        btn_in = 2'b01;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) btn_in = 2'b11;
            tick_chk("stag", {k >= 6, k >= 5}, {k == 6, k == 5}, 2'b00, 2'b00);
        end
        btn_in = 2'b00;
        for (int k = 0; k < 7; k++)
            tick_chk("stag_rel", (k < 5) ? 2'b11 : 2'b00, 2'b00, (k == 5) ? 2'b11 : 2'b00, 2'b00);

        // Reset during a repeating hold, input kept high.
        rpt_en = 1'b1;
        btn_in = 2'b01;
        for (int k = 0; k < 17; k++)
            tick_chk("pre_rst", (k >= 5) ? 2'b01 : 2'b00, (k == 5) ? 2'b01 : 2'b00, 2'b00,
                     (k == 15) ? 2'b01 : 2'b00);
        rst_n = 1'b0;
        tick_chk("mid_rst", 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1;
        for (int k = 0; k < 19; k++)
            tick_chk("post_rst", (k >= 5) ? 2'b01 : 2'b00, (k == 5) ? 2'b01 : 2'b00, 2'b00,
                     (k == 15 || k == 18) ? 2'b01 : 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
